// File: rtl/aes_stream_pkg.sv
// ---------------------------------------------------------------------------
// aes_stream_pkg
// Shared widths, the packer FSM state type and a helper that builds the
// output beat from a cipher block and its bypass bits.
//   CIPHER_W : width of one AES cipher block
//   BYPASS_W : width of the header/bypass field that travels with the block
//   TDATA_W  : width of the output stream beat, {cipher, bypass}
// ---------------------------------------------------------------------------
package aes_stream_pkg;

    localparam int CIPHER_W = 128;
    localparam int BYPASS_W = 289;
    localparam int TDATA_W  = CIPHER_W + BYPASS_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // between packets, next accepted word starts a packet
        ST_PKT  = 2'd1,   // packet in progress, words are being buffered
        ST_DROP = 2'd2    // packet in progress, words are being discarded
    } pkt_state_e;

    // Cipher occupies the MSBs; cipher bit 0 lands on tdata bit TDATA_W-1.
    function automatic logic [TDATA_W-1:0] pack_tdata(
        input logic [0:CIPHER_W-1] cipher,
        input logic [BYPASS_W-1:0] bypass
    );
        return {cipher, bypass};
    endfunction

endpackage

// File: rtl/aes_out_packer_if.sv
// ---------------------------------------------------------------------------
// aes_out_packer_if
// Output stream bundle of the AES output packer.
//   tdata  : {cipher[0:127], bypass[288:0]}, cipher in the MSBs
//   tvalid : beat available
//   tready : downstream accepts the beat
//   tlast  : final beat of a packet
//   terr   : packet was truncated (set together with tlast)
// master = packer side, slave = downstream consumer side.
// ---------------------------------------------------------------------------
interface aes_out_packer_if;
    import aes_stream_pkg::*;

    logic [TDATA_W-1:0] tdata;
    logic               tvalid;
    logic               tready;
    logic               tlast;
    logic               terr;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output terr,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  terr,
        output tready
    );

endinterface

// File: rtl/packer_fifo.sv
// ---------------------------------------------------------------------------
// packer_fifo
// First-word-fall-through FIFO with occupancy outputs.
//   clk, reset  : clock, synchronous active-high reset (empties the FIFO)
//   wr_en       : push wr_data (caller guarantees the FIFO is not full)
//   rd_en       : pop the head entry (ignored while empty)
//   rd_data     : head entry, valid whenever !empty, all-zero while empty
//   empty       : no entries stored
//   count       : entries stored now
//   count_next  : entries stored after the coming edge
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// A word pushed at edge N is visible on rd_data right after edge N, so the
// storage is read asynchronously (distributed RAM style).
// ---------------------------------------------------------------------------
module packer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_next
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop, full;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign push  = wr_en;
    assign pop   = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Push and pop together leave the occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; stale contents are never exposed because
    // rd_data is forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data    = empty ? '0 : mem[rd_ptr_q];
    assign count      = count_q;
    assign count_next = count_d;

    // The admission FSM upstream keeps at least one free slot in reserve,
    // so a push into a full FIFO must never happen.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(wr_en && full));

endmodule

// File: rtl/aes_out_packer.sv
// ---------------------------------------------------------------------------
// aes_out_packer
// Packs AES cipher blocks plus their bypass bits into a buffered output
// stream, admitting whole packets only while there is room and truncating
// (tlast+terr) or discarding packets when the buffer runs out.
//   clk, reset     : sole clock, synchronous active-high reset
//   i_cp_ready     : input word valid this cycle (no upstream backpressure)
//   i_cipher_text  : cipher block, i_bypass_text : header/bypass bits
//   i_last         : final word of the packet
//   m_axis         : output stream (tdata/tvalid/tready/tlast/terr)
//   o_almost_full  : registered throttle hint, free entries <= AFULL_MARGIN
//   o_drop         : one-cycle pulse, registered, after the edge at which a
//                    packet starts being discarded
//   o_pkt_count    : tlast beats delivered (statistics build only)
//   o_drop_count   : o_drop pulses (statistics build only)
// Build option: define AES_PACKER_STATS_EN to include the two wrapping
// statistics counters; otherwise both outputs are constant zero.
// ---------------------------------------------------------------------------
module aes_out_packer
    import aes_stream_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_cp_ready,
    input  logic [0:CIPHER_W-1]   i_cipher_text,
    input  logic [BYPASS_W-1:0]   i_bypass_text,
    input  logic                  i_last,
    aes_out_packer_if.master      m_axis,
    output logic                  o_almost_full,
    output logic                  o_drop,
    output logic [31:0]           o_pkt_count,
    output logic [15:0]           o_drop_count
);

    localparam int CW      = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = TDATA_W + 2;

    pkt_state_e         state_q, state_d;
    logic               wr_en, wr_last, wr_err;
    logic               drop_d, drop_q;
    logic               almost_full_d, almost_full_q;
    logic               rd_en, fifo_empty;
    logic [CW-1:0]      fifo_count, fifo_count_next;
    logic [CW-1:0]      free_now, free_next;
    logic [ENTRY_W-1:0] wr_entry, rd_entry;

    // Admission looks only at occupancy before the edge; a pop in the same
    // cycle is deliberately not credited.
    assign free_now = CW'(DEPTH) - fifo_count;
    assign rd_en    = m_axis.tvalid && m_axis.tready;

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        wr_last = 1'b0;
        wr_err  = 1'b0;
        drop_d  = 1'b0;
        if (i_cp_ready) begin
            unique case (state_q)
                ST_IDLE: begin
                    // A new packet needs two slots so that, if it runs long,
                    // there is always room left for a truncating tlast beat.
                    if (free_now >= CW'(2)) begin
                        wr_en   = 1'b1;
                        wr_last = i_last;
                        state_d = i_last ? ST_IDLE : ST_PKT;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = i_last ? ST_IDLE : ST_DROP;
                    end
                end
                ST_PKT: begin
                    // Inside an admitted packet at least one slot is free.
                    wr_en = 1'b1;
                    if (i_last) begin
                        wr_last = 1'b1;
                        state_d = ST_IDLE;
                    end else if (free_now < CW'(2)) begin
                        // Last slot: close the packet as truncated.
                        wr_last = 1'b1;
                        wr_err  = 1'b1;
                        drop_d  = 1'b1;
                        state_d = ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (i_last) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            drop_q        <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            drop_q        <= drop_d;
            almost_full_q <= almost_full_d;
        end
    end

    assign wr_entry = {pack_tdata(i_cipher_text, i_bypass_text), wr_last, wr_err};

    packer_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_entry),
        .rd_en      (rd_en),
        .rd_data    (rd_entry),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .count_next (fifo_count_next)
    );

    assign m_axis.tvalid = !fifo_empty;
    assign {m_axis.tdata, m_axis.tlast, m_axis.terr} = rd_entry;

    // Registered from the post-edge occupancy so the flag matches the count
    // the FIFO holds during the cycle it is visible.
    assign free_next     = CW'(DEPTH) - fifo_count_next;
    assign almost_full_d = (free_next <= CW'(AFULL_MARGIN));
    assign o_almost_full = almost_full_q;
    assign o_drop        = drop_q;

`ifdef AES_PACKER_STATS_EN
    logic [31:0] pkt_count_q, pkt_count_d;
    logic [15:0] drop_count_q, drop_count_d;

    always_comb begin
        pkt_count_d  = pkt_count_q;
        drop_count_d = drop_count_q;
        if (rd_en && m_axis.tlast) begin
            pkt_count_d = pkt_count_q + 32'd1;
        end
        // Counted at the same edge that raises o_drop.
        if (drop_d) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            pkt_count_q  <= pkt_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign o_pkt_count  = pkt_count_q;
    assign o_drop_count = drop_count_q;
`else
    assign o_pkt_count  = '0;
    assign o_drop_count = '0;
`endif

endmodule

// File: tb/tb_aes_out_packer.sv
// ---------------------------------------------------------------------------
// tb_aes_out_packer
// Self-checking bench for aes_out_packer (DEPTH=16, AFULL_MARGIN=4): a table
// of hand-derived vectors, directed corner sequences and a randomized run
// compared every cycle against a queue-based reference model.
// Honours AES_PACKER_STATS_EN for the statistics outputs.
// ---------------------------------------------------------------------------
module tb_aes_out_packer;
    import aes_stream_pkg::*;

    localparam int DEPTH = 16;
    localparam int AFULL = 4;
`ifdef AES_PACKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                cp_ready;
    logic [0:CIPHER_W-1] cipher;
    logic [BYPASS_W-1:0] bypass;
    logic                last;
    logic                almost_full;
    logic                drop;
    logic [31:0]         pkt_count;
    logic [15:0]         drop_count;

    aes_out_packer_if bus ();

    aes_out_packer #(
        .DEPTH        (DEPTH),
        .AFULL_MARGIN (AFULL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_cp_ready    (cp_ready),
        .i_cipher_text (cipher),
        .i_bypass_text (bypass),
        .i_last        (last),
        .m_axis        (bus),
        .o_almost_full (almost_full),
        .o_drop        (drop),
        .o_pkt_count   (pkt_count),
        .o_drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chkd(input string name, input logic [TDATA_W-1:0] act, input logic [TDATA_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Distinct, recognisable beat per id; cipher and bypass differ so a swap shows.
    function automatic logic [TDATA_W-1:0] mk(input int id);
        logic [0:CIPHER_W-1] c;
        logic [BYPASS_W-1:0] b;
        c = {4{id ^ 32'hA5C3_0000}};
        b = {id[0], {9{id}}};
        return {c, b};
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [TDATA_W-1:0] data;
        logic               last;
        logic               err;
    } ent_t;

    ent_t mq[$];        // words the FIFO should hold, head first
    int   m_mode;       // 0: between packets, 1: keeping a packet, 2: discarding a packet
    logic m_drop;
    logic m_af;
    int   m_pkt;
    int   m_dropc;

    ent_t got[$];       // beats actually handed downstream
    int   drop_seen;

    task automatic model_step();
        ent_t e;
        int   occ;
        int   fr;
        bit   push;
        bit   nd;
        if (reset) begin
            mq.delete();
            m_mode  = 0;
            m_drop  = 1'b0;
            m_af    = 1'b0;
            m_pkt   = 0;
            m_dropc = 0;
            return;
        end
        occ    = mq.size();
        fr     = DEPTH - occ;
        push   = 1'b0;
        nd     = 1'b0;
        e.data = {cipher, bypass};
        e.last = last;
        e.err  = 1'b0;
        if (cp_ready) begin
            if (m_mode == 0) begin
                if (fr >= 2) begin
                    push   = 1'b1;
                    m_mode = last ? 0 : 1;
                end else begin
                    nd     = 1'b1;
                    m_mode = last ? 0 : 2;
                end
            end else if (m_mode == 1) begin
                push = 1'b1;
                if (last) begin
                    m_mode = 0;
                end else if (fr < 2) begin
                    e.last = 1'b1;
                    e.err  = 1'b1;
                    nd     = 1'b1;
                    m_mode = 2;
                end
            end else if (last) begin
                m_mode = 0;
            end
        end
        if (occ > 0 && bus.tready) begin
            if (mq[0].last) m_pkt++;
            mq.delete(0);
        end
        if (push) mq.push_back(e);
        m_drop = nd;
        if (nd) m_dropc++;
        m_af = ((DEPTH - mq.size()) <= AFULL);
    endtask

    task automatic model_chk();
        chk1("tvalid", bus.tvalid, mq.size() > 0);
        if (mq.size() > 0) begin
            chkd("tdata", bus.tdata, mq[0].data);
            chk1("tlast", bus.tlast, mq[0].last);
            chk1("terr", bus.terr, mq[0].err);
        end
        chk1("drop", drop, m_drop);
        chk1("almost_full", almost_full, m_af);
        chk32("pkt_count", pkt_count, STATS ? m_pkt : 0);
        chk32("drop_count", {16'd0, drop_count}, STATS ? {16'd0, m_dropc[15:0]} : 32'd0);
    endtask

    // One clock: model predicts, DUT clocks, outputs sampled 1ns after the edge.
    task automatic tick();
        ent_t e;
        if (bus.tvalid === 1'b1 && bus.tready === 1'b1) begin
            e.data = bus.tdata;
            e.last = bus.tlast;
            e.err  = bus.terr;
            got.push_back(e);
        end
        model_step();
        @(posedge clk);
        #1;
        if (drop === 1'b1) drop_seen++;
        model_chk();
    endtask

    task automatic word(input int id, input bit lst);
        cp_ready         = 1'b1;
        {cipher, bypass} = mk(id);
        last             = lst;
        tick();
        cp_ready = 1'b0;
        last     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        cp_ready = 1'b0;
        last     = 1'b0;
        tick();
        tick();
        reset     = 1'b0;
        drop_seen = 0;
        got.delete();
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic       cp;
        logic       lst;
        logic       rdy;
        int         id;
        logic       e_valid;
        logic       e_last;
        int         e_id;
        logic [31:0] e_pkt;
    } vec_t;

    vec_t tv[8];

    function automatic vec_t v(input logic cp, input logic lst, input logic rdy, input int id,
                               input logic ev, input logic el, input int eid, input int ep);
        vec_t r;
        r.cp = cp; r.lst = lst; r.rdy = rdy; r.id = id;
        r.e_valid = ev; r.e_last = el; r.e_id = eid; r.e_pkt = ep;
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        cp_ready   = 1'b0;
        cipher     = '0;
        bypass     = '0;
        last       = 1'b0;
        bus.tready = 1'b0;
        m_mode = 0; m_drop = 1'b0; m_af = 1'b0; m_pkt = 0; m_dropc = 0; drop_seen = 0;

        // 3-word packet with tready=1, then two single-word packets held and released.
        tv[0] = v(1, 0, 1, 1, 1, 0, 1, 0);
        tv[1] = v(1, 0, 1, 2, 1, 0, 2, 0);
        tv[2] = v(1, 1, 1, 3, 1, 1, 3, 0);
        tv[3] = v(0, 0, 1, 0, 0, 0, 0, 1);
        tv[4] = v(1, 1, 0, 4, 1, 1, 4, 1);
        tv[5] = v(1, 1, 0, 5, 1, 1, 4, 1);
        tv[6] = v(0, 0, 1, 0, 1, 1, 5, 2);
        tv[7] = v(0, 0, 1, 0, 0, 0, 0, 3);

        // ---- reset state ----
        do_reset();
        chk1("rst_tvalid", bus.tvalid, 1'b0);
        chkd("rst_tdata", bus.tdata, '0);
        chk1("rst_tlast", bus.tlast, 1'b0);
        chk1("rst_terr", bus.terr, 1'b0);
        chk1("rst_afull", almost_full, 1'b0);
        chk1("rst_drop", drop, 1'b0);
        chk32("rst_pkt_count", pkt_count, 32'd0);
        chk32("rst_drop_count", {16'd0, drop_count}, 32'd0);

        // ---- table ----
        for (int i = 0; i < 8; i++) begin
            cp_ready         = tv[i].cp;
            last             = tv[i].lst;
            bus.tready       = tv[i].rdy;
            {cipher, bypass} = mk(tv[i].id);
            tick();
            chk1($sformatf("vec%0d_tvalid", i), bus.tvalid, tv[i].e_valid);
            if (tv[i].e_valid) begin
                chkd($sformatf("vec%0d_tdata", i), bus.tdata, mk(tv[i].e_id));
                chk1($sformatf("vec%0d_tlast", i), bus.tlast, tv[i].e_last);
                chk1($sformatf("vec%0d_terr", i), bus.terr, 1'b0);
            end
            chk32($sformatf("vec%0d_pkt_count", i), pkt_count, STATS ? tv[i].e_pkt : 32'd0);
        end
        cp_ready = 1'b0;
        last     = 1'b0;

        // ---- 20 single-word packets into a stalled stream ----
        do_reset();
        bus.tready = 1'b0;
        for (int i = 0; i < 20; i++) word(i, 1'b1);
        chk32("fill_drop_pulses", drop_seen, 32'd5);
        chk32("fill_drop_count", {16'd0, drop_count}, STATS ? 32'd5 : 32'd0);
        bus.tready = 1'b1;
        idle(20);
        chk32("fill_stored", got.size(), 32'd15);
        if (got.size() == 15) chkd("fill_last_word", got[14].data, mk(14));

        // ---- packet truncated at the last free slot ----
        do_reset();
        bus.tready = 1'b0;
        for (int i = 0; i < 14; i++) word(100 + i, 1'b1);
        for (int i = 0; i < 6; i++) word(200 + i, i == 5);
        chk32("trunc_drop_pulses", drop_seen, 32'd1);
        bus.tready = 1'b1;
        idle(20);
        chk32("trunc_stored", got.size(), 32'd16);
        if (got.size() == 16) begin
            chkd("trunc_w1_data", got[14].data, mk(200));
            chk1("trunc_w1_last", got[14].last, 1'b0);
            chk1("trunc_w1_err", got[14].err, 1'b0);
            chkd("trunc_w2_data", got[15].data, mk(201));
            chk1("trunc_w2_last", got[15].last, 1'b1);
            chk1("trunc_w2_err", got[15].err, 1'b1);
        end
        bus.tready = 1'b0;
        word(300, 1'b1);
        chk1("trunc_idle_accepts", bus.tvalid, 1'b1);
        chkd("trunc_idle_data", bus.tdata, mk(300));

        // ---- push and pop together near full, across pointer wrap ----
        do_reset();
        bus.tready = 1'b0;
        for (int i = 0; i < 15; i++) word(400 + i, 1'b0);
        bus.tready = 1'b1;
        word(415, 1'b1);
        chkd("wrap_head", bus.tdata, mk(401));
        chk1("wrap_afull", almost_full, 1'b1);
        idle(1);
        for (int i = 0; i < 40; i++) word(500 + i, i == 39);
        idle(20);
        chk32("wrap_drop_pulses", drop_seen, 32'd0);
        chk32("wrap_total", got.size(), 32'd56);
        if (got.size() == 56) begin
            for (int k = 0; k < 56; k++) begin
                chkd($sformatf("wrap_order%0d", k), got[k].data, mk(k < 16 ? 400 + k : 500 + k - 16));
            end
            chk1("wrap_last_a", got[15].last, 1'b1);
            chk1("wrap_last_b", got[55].last, 1'b1);
        end

        // ---- reset in the middle of a packet ----
        do_reset();
        bus.tready = 1'b0;
        word(600, 1'b0);
        word(601, 1'b0);
        reset            = 1'b1;
        cp_ready         = 1'b1;
        {cipher, bypass} = mk(602);
        tick();
        chk1("midrst_tvalid", bus.tvalid, 1'b0);
        reset    = 1'b0;
        cp_ready = 1'b0;
        got.delete();
        bus.tready = 1'b1;
        word(700, 1'b0);
        word(701, 1'b1);
        idle(3);
        chk32("midrst_count", got.size(), 32'd2);
        if (got.size() == 2) begin
            chkd("midrst_w0", got[0].data, mk(700));
            chk1("midrst_w0_last", got[0].last, 1'b0);
            chkd("midrst_w1", got[1].data, mk(701));
            chk1("midrst_w1_last", got[1].last, 1'b1);
        end

        // ---- almost_full threshold ----
        do_reset();
        bus.tready = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            word(800 + k, 1'b1);
            chk1($sformatf("afull_k%0d", k), almost_full, k >= 12);
        end
        bus.tready = 1'b1;
        tick();
        chk1("afull_fall", almost_full, 1'b0);

        // ---- randomized run against the model ----
        do_reset();
        begin
            int thr;
            thr = 50;
            for (int c = 0; c < 3000; c++) begin
                if (c % 200 == 0) thr = (c / 200) % 3 == 0 ? 15 : ((c / 200) % 3 == 1 ? 55 : 90);
                reset      = ($urandom_range(499) == 0);
                cp_ready   = ($urandom_range(3) != 0);
                last       = ($urandom_range(3) == 0);
                bus.tready = ($urandom_range(99) < thr);
                cipher     = {$urandom, $urandom, $urandom, $urandom};
                bypass     = {1'($urandom), $urandom, $urandom, $urandom, $urandom,
                              $urandom, $urandom, $urandom, $urandom, $urandom};
                tick();
            end
            reset    = 1'b0;
            cp_ready = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
